// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the datamem self-test master.
package mem_bist_pkg;

    localparam int WORD_BYTES = 4;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        RD_A,
        WR_B,
        RD_B,
        DONE
    } state_t;

    function automatic logic [DATA_W-1:0] exp_data(
        input logic              pass_b,
        input logic [ADDR_W-1:0] addr
    );
        return pass_b ? ~addr : addr;
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Word index counter and byte address generator for the BIST sweep.
module bist_addr_gen
    import mem_bist_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       NUM_WORDS = 64,
    parameter int unsigned       ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    output logic [ADDR_W-1:0] address,
    output logic              last
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [IDX_W-1:0] idx;

    assign last = (idx == LAST_IDX);

    // Stepping past the last word rewinds, ready for the next sweep.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx     <= '0;
            address <= BASE_ADDR;
        end else if (step) begin
            if (last) begin
                idx     <= '0;
                address <= BASE_ADDR;
            end else begin
                idx     <= idx + IDX_W'(1);
                address <= address + ADDR_W'(ADDR_STEP);
            end
        end
    end

endmodule

// File: rtl/mem_bist_master.sv
// Two-pass address / inverse-address self-test driving datamem directly.
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned       NUM_WORDS = 64,
    parameter int unsigned       ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] Writedata,
    output logic              memread,
    output logic              memwrite,
    input  logic [DATA_W-1:0] readdata
);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic              last;
    logic              is_wr;
    logic              is_rd;
    logic              pass_b;
    logic              accept;
    logic              mismatch;
    logic              step;
    logic [DATA_W-1:0] exp_word;

    bist_addr_gen #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_WORDS (NUM_WORDS),
        .ADDR_STEP (ADDR_STEP)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .step    (step),
        .address (cur_addr),
        .last    (last)
    );

    always_comb begin
        is_wr    = (state == WR_A) || (state == WR_B);
        is_rd    = (state == RD_A) || (state == RD_B);
        pass_b   = (state == WR_B) || (state == RD_B);
        accept   = start && ((state == IDLE) || (state == DONE));
        exp_word = exp_data(pass_b, cur_addr);
        mismatch = is_rd && (readdata != exp_word);
        step     = is_wr || (is_rd && !mismatch);
    end

    // Memory pins are quiet (all zero) outside the sweep states.
    assign address   = (is_wr || is_rd) ? cur_addr : '0;
    assign Writedata = is_wr ? exp_word : '0;
    assign memread   = is_rd;
    assign memwrite  = is_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state     <= WR_A;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_addr <= '0;
                        fail_exp  <= '0;
                        fail_act  <= '0;
                    end
                end
                WR_A: begin
                    if (last) state <= RD_A;
                end
                WR_B: begin
                    if (last) state <= RD_B;
                end
                RD_A, RD_B: begin
                    if (mismatch) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail_addr <= cur_addr;
                        fail_exp  <= exp_word;
                        fail_act  <= readdata;
                    end else if (last) begin
                        if (state == RD_A) begin
                            state <= WR_B;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_master.sv
// Randomised self-checking bench for mem_bist_master against an access-list model.
module tb_mem_bist_master;

    localparam int          NW    = 4;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFF8;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start     [2];
    logic        busy      [2];
    logic        done      [2];
    logic        pass      [2];
    logic        memread   [2];
    logic        memwrite  [2];
    logic [31:0] fail_addr [2];
    logic [31:0] fail_exp  [2];
    logic [31:0] fail_act  [2];
    logic [31:0] address   [2];
    logic [31:0] wdata     [2];
    logic [31:0] readdata  [2];
    logic [31:0] off       [2];

    always #5 clk = ~clk;

    mem_bist_master #(
        .BASE_ADDR (BASE0),
        .NUM_WORDS (NW),
        .ADDR_STEP (4)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start[0]),
        .busy      (busy[0]),
        .done      (done[0]),
        .pass      (pass[0]),
        .fail_addr (fail_addr[0]),
        .fail_exp  (fail_exp[0]),
        .fail_act  (fail_act[0]),
        .address   (address[0]),
        .Writedata (wdata[0]),
        .memread   (memread[0]),
        .memwrite  (memwrite[0]),
        .readdata  (readdata[0])
    );

    mem_bist_master #(
        .BASE_ADDR (BASE1),
        .NUM_WORDS (NW),
        .ADDR_STEP (4)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start[1]),
        .busy      (busy[1]),
        .done      (done[1]),
        .pass      (pass[1]),
        .fail_addr (fail_addr[1]),
        .fail_exp  (fail_exp[1]),
        .fail_act  (fail_act[1]),
        .address   (address[1]),
        .Writedata (wdata[1]),
        .memread   (memread[1]),
        .memwrite  (memwrite[1]),
        .readdata  (readdata[1])
    );

    // Word storage indexed by offset from each instance's base.
    logic [31:0] mem0 [NW];
    logic [31:0] mem1 [NW];

    int          sel     = 0;
    bit          st_en   = 1'b0;
    logic [31:0] st_addr = 32'h0;
    int          st_bit  = 0;
    logic        st_val  = 1'b0;
    bit          pb_zero = 1'b0;
    int          rd_cnt  = 0;
    int          rd_base = 0;
    int          busy_cnt = 0;
    int          both_cnt = 0;
    acc_t        trace [$];

    int n_chk  = 0;
    int n_fail = 0;

    acc_t        exp_q [$];
    bit          e_fail;
    logic [31:0] e_fa;
    logic [31:0] e_fe;
    logic [31:0] e_fx;

    assign off[0] = address[0] - BASE0;
    assign off[1] = address[1] - BASE1;

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            readdata[g] = 32'h0;
            if (memread[g]) begin
                readdata[g] = (g == 0) ? mem0[off[0][3:2]] : mem1[off[1][3:2]];
                if (g == sel && st_en && address[g] == st_addr)
                    readdata[g][st_bit] = st_val;
                if (g == sel && pb_zero && (rd_cnt - rd_base) >= NW)
                    readdata[g] = 32'h0;
            end
        end
    end

    always @(posedge clk) begin
        if (memwrite[0]) mem0[off[0][3:2]] <= wdata[0];
        if (memwrite[1]) mem1[off[1][3:2]] <= wdata[1];
        if (memread[sel]) rd_cnt <= rd_cnt + 1;
    end

    always @(negedge clk) begin
        if (memwrite[sel] || memread[sel])
            trace.push_back('{we: memwrite[sel], a: address[sel], d: wdata[sel]});
        if (busy[sel]) busy_cnt <= busy_cnt + 1;
        if (memwrite[sel] && memread[sel]) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected access list and outcome, derived from the test rules.
    task automatic predict(input logic [31:0] base);
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] v;
        exp_q.delete();
        e_fail = 1'b0;
        e_fa   = 32'h0;
        e_fe   = 32'h0;
        e_fx   = 32'h0;
        for (int p = 0; p < 2 && !e_fail; p++) begin
            for (int i = 0; i < NW; i++) begin
                a = base + 32'(i * 4);
                d = (p == 1) ? ~a : a;
                exp_q.push_back('{we: 1'b1, a: a, d: d});
            end
            for (int i = 0; i < NW && !e_fail; i++) begin
                a = base + 32'(i * 4);
                d = (p == 1) ? ~a : a;
                exp_q.push_back('{we: 1'b0, a: a, d: 32'h0});
                v = d;
                if (st_en && a == st_addr) v[st_bit] = st_val;
                if (pb_zero && p == 1) v = 32'h0;
                if (v != d) begin
                    e_fail = 1'b1;
                    e_fa   = a;
                    e_fe   = d;
                    e_fx   = v;
                end
            end
        end
    endtask

    task automatic run(input int g, input string tag, input bit kick_en);
        logic [31:0] base;
        int tb;
        int bb;
        int kick;
        int cyc;
        base = (g == 0) ? BASE0 : BASE1;
        sel  = g;
        predict(base);
        @(negedge clk);
        tb      = trace.size();
        bb      = busy_cnt;
        rd_base = rd_cnt;
        kick    = kick_en ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        check({tag, "/busy_on"}, busy[g], 1);
        check({tag, "/done_clr"}, done[g], 0);
        check({tag, "/fail_addr_clr"}, fail_addr[g], 0);
        check({tag, "/first_addr"}, address[g], base);
        check({tag, "/first_we"}, memwrite[g], 1);
        cyc = 0;
        while (!done[g] && cyc < 200) begin
            start[g] = (cyc == kick);
            @(negedge clk);
            cyc++;
        end
        start[g] = 1'b0;
        check({tag, "/done"}, done[g], 1);
        check({tag, "/busy_cycles"}, busy_cnt - bb, exp_q.size());
        check({tag, "/n_access"}, trace.size() - tb, exp_q.size());
        for (int i = 0; i < exp_q.size() && tb + i < trace.size(); i++) begin
            check($sformatf("%s/acc%0d_we", tag, i), trace[tb+i].we, exp_q[i].we);
            check($sformatf("%s/acc%0d_addr", tag, i), trace[tb+i].a, exp_q[i].a);
            check($sformatf("%s/acc%0d_data", tag, i), trace[tb+i].d, exp_q[i].d);
        end
        check({tag, "/pass"}, pass[g], !e_fail);
        check({tag, "/fail_addr"}, fail_addr[g], e_fa);
        check({tag, "/fail_exp"}, fail_exp[g], e_fe);
        check({tag, "/fail_act"}, fail_act[g], e_fx);
        check({tag, "/busy_off"}, busy[g], 0);
        tb = trace.size();
        repeat (3) @(negedge clk);
        check({tag, "/quiet"}, trace.size() - tb, 0);
        check({tag, "/done_hold"}, done[g], 1);
        check({tag, "/rw_excl"}, both_cnt, 0);
    endtask

    task automatic abort_run();
        int tb;
        sel = 0;
        @(negedge clk);
        tb = trace.size();
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2 * NW + 2) @(negedge clk);
        check("abort/wrb_we", memwrite[0], 1);
        check("abort/wrb_addr", address[0], 32'h8);
        check("abort/wrb_data", wdata[0], 32'hFFFF_FFF7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort/memwrite", memwrite[0], 0);
        check("abort/memread", memread[0], 0);
        check("abort/busy", busy[0], 0);
        check("abort/done", done[0], 0);
        check("abort/fail_addr", fail_addr[0], 0);
        check("abort/fail_exp", fail_exp[0], 0);
        check("abort/fail_act", fail_act[0], 0);
        check("abort/address", address[0], 0);
        @(negedge clk);
        check("abort/n_access", trace.size() - tb, 2 * NW + 3);
    endtask

    initial begin
        logic [31:0] base;
        int g;
        start[0] = 1'b0;
        start[1] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst/busy", busy[k], 0);
            check("rst/done", done[k], 0);
            check("rst/pass", pass[k], 0);
            check("rst/fail_addr", fail_addr[k], 0);
            check("rst/address", address[k], 0);
            check("rst/wdata", wdata[k], 0);
            check("rst/memread", memread[k], 0);
            check("rst/memwrite", memwrite[k], 0);
        end
        rst = 1'b0;

        run(0, "clean", 1'b0);

        st_en = 1'b1; st_addr = 32'h8; st_bit = 3; st_val = 1'b0;
        run(0, "stuck", 1'b0);
        check("stuck/fa_const", fail_addr[0], 32'h8);
        check("stuck/fx_const", fail_act[0], 32'h0);
        st_en = 1'b0;

        run(0, "restart", 1'b1);

        pb_zero = 1'b1;
        run(0, "pbzero", 1'b1);
        check("pbzero/fe_const", fail_exp[0], 32'hFFFF_FFFF);
        pb_zero = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_done/fail_exp", fail_exp[0], 0);
        check("rst_done/done", done[0], 0);

        abort_run();
        run(0, "after_rst", 1'b0);

        run(1, "wrap", 1'b1);

        repeat (6) begin
            g       = int'($urandom_range(0, 1));
            base    = (g == 0) ? BASE0 : BASE1;
            st_en   = 1'($urandom_range(0, 1));
            st_addr = base + 32'(4 * $urandom_range(0, NW - 1));
            st_bit  = int'($urandom_range(0, 31));
            st_val  = 1'($urandom_range(0, 1));
            pb_zero = ($urandom_range(0, 3) == 0);
            run(g, "rand", 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
